// File: rtl/ftdi_fifo_responder.sv
// ftdi_fifo_responder: stand-in for an FT245-style synchronous FIFO device.
// It holds two first-word-fall-through byte FIFOs:
//   RX: the host pushes bytes with a valid/ready handshake; the SNES side pops them with ft_rd_n.
//   TX: the SNES side pushes bytes with ft_wr_n; the host pops them with a valid/ready handshake.
// Ports:
//   clk, rst_n               FIFO clock, asynchronous active-low reset
//   ft_rd_n, ft_wr_n         pop strobe (RX) and push strobe (TX), level-sampled on rising clk
//   ft_oe_n, ft_data_oe      output enable for the data pins and its active-high copy
//   ft_rxf_n, ft_txe_n       RX not-empty (active low), TX not-full (active low)
//   ft_data_in, ft_data_out  byte written by the SNES side, head of the RX FIFO
//   host_rx_*                host-to-SNES byte stream (push side of RX)
//   host_tx_*                SNES-to-host byte stream (pop side of TX)
//   rx_level, tx_level       FIFO occupancy
//   err_underrun, err_overrun, clr_err  sticky strobe-error flags and their synchronous clear
module ftdi_fifo_responder #(
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ft_rd_n,
  input  logic              ft_wr_n,
  input  logic              ft_oe_n,
  output logic              ft_rxf_n,
  output logic              ft_txe_n,
  input  logic [7:0]        ft_data_in,
  output logic [7:0]        ft_data_out,
  output logic              ft_data_oe,
  input  logic [7:0]        host_rx_data,
  input  logic              host_rx_valid,
  output logic              host_rx_ready,
  output logic [7:0]        host_tx_data,
  output logic              host_tx_valid,
  input  logic              host_tx_ready,
  output logic [DEPTH_LOG2:0] rx_level,
  output logic [DEPTH_LOG2:0] tx_level,
  output logic              err_underrun,
  output logic              err_overrun,
  input  logic              clr_err
);

  localparam int unsigned PtrW  = DEPTH_LOG2 + 1;
  localparam int unsigned Depth = 1 << DEPTH_LOG2;
  localparam logic [PtrW-1:0] FullLvl = PtrW'(Depth);
  localparam logic [PtrW-1:0] PtrOne  = PtrW'(1);

  logic [7:0] rx_mem [Depth];
  logic [7:0] tx_mem [Depth];

  logic [PtrW-1:0] rx_wr_q, rx_rd_q, tx_wr_q, tx_rd_q;
  logic            err_underrun_q, err_overrun_q;

  logic rx_empty, rx_full, tx_empty, tx_full;
  logic rx_push, rx_pop, tx_push, tx_pop;
  logic underrun_evt, overrun_evt;

  // Extra pointer bit separates full from empty, so the level is just the pointer difference.
  always_comb begin
    rx_level = rx_wr_q - rx_rd_q;
    tx_level = tx_wr_q - tx_rd_q;
    rx_empty = (rx_level == '0);
    rx_full  = (rx_level == FullLvl);
    tx_empty = (tx_level == '0);
    tx_full  = (tx_level == FullLvl);

    // All accept decisions use pre-edge state; a concurrent pop never frees room for a push.
    rx_push      = host_rx_valid & ~rx_full;
    rx_pop       = ~ft_rd_n & ~rx_empty;
    tx_push      = ~ft_wr_n & ~tx_full;
    tx_pop       = host_tx_ready & ~tx_empty;
    underrun_evt = ~ft_rd_n & rx_empty;
    overrun_evt  = ~ft_wr_n & tx_full;
  end

  always_comb begin
    ft_rxf_n      = rx_empty;
    ft_txe_n      = tx_full;
    host_rx_ready = ~rx_full;
    host_tx_valid = ~tx_empty;
    ft_data_oe    = ~ft_oe_n;
    ft_data_out   = rx_empty ? 8'h00 : rx_mem[rx_rd_q[DEPTH_LOG2-1:0]];
    host_tx_data  = tx_empty ? 8'h00 : tx_mem[tx_rd_q[DEPTH_LOG2-1:0]];
    err_underrun  = err_underrun_q;
    err_overrun   = err_overrun_q;
  end

  // Storage carries no reset; stale contents are unreachable once the pointers are cleared.
  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wr_q[DEPTH_LOG2-1:0]] <= host_rx_data;
    if (tx_push) tx_mem[tx_wr_q[DEPTH_LOG2-1:0]] <= ft_data_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_wr_q        <= '0;
      rx_rd_q        <= '0;
      tx_wr_q        <= '0;
      tx_rd_q        <= '0;
      err_underrun_q <= 1'b0;
      err_overrun_q  <= 1'b0;
    end else begin
      if (rx_push) rx_wr_q <= rx_wr_q + PtrOne;
      if (rx_pop)  rx_rd_q <= rx_rd_q + PtrOne;
      if (tx_push) tx_wr_q <= tx_wr_q + PtrOne;
      if (tx_pop)  tx_rd_q <= tx_rd_q + PtrOne;

      // A fresh error on the clearing edge takes priority over the clear.
      if (underrun_evt)  err_underrun_q <= 1'b1;
      else if (clr_err)  err_underrun_q <= 1'b0;
      if (overrun_evt)   err_overrun_q  <= 1'b1;
      else if (clr_err)  err_overrun_q  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ftdi_fifo_responder.sv
// Directed testbench for ftdi_fifo_responder: one task per scenario, inline comparisons.
module tb_ftdi_fifo_responder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ft_rd_n, ft_wr_n, ft_oe_n;
  logic       ft_rxf_n, ft_txe_n;
  logic [7:0] ft_data_in, ft_data_out;
  logic       ft_data_oe;
  logic [7:0] host_rx_data;
  logic       host_rx_valid, host_rx_ready;
  logic [7:0] host_tx_data;
  logic       host_tx_valid, host_tx_ready;
  logic [4:0] rx_level, tx_level;
  logic       err_underrun, err_overrun, clr_err;

  int tests_run = 0;
  int tests_failed = 0;

  logic [7:0] rx_q[$];
  logic [7:0] tx_q[$];

  ftdi_fifo_responder #(.DEPTH_LOG2(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ft_rd_n      (ft_rd_n),
    .ft_wr_n      (ft_wr_n),
    .ft_oe_n      (ft_oe_n),
    .ft_rxf_n     (ft_rxf_n),
    .ft_txe_n     (ft_txe_n),
    .ft_data_in   (ft_data_in),
    .ft_data_out  (ft_data_out),
    .ft_data_oe   (ft_data_oe),
    .host_rx_data (host_rx_data),
    .host_rx_valid(host_rx_valid),
    .host_rx_ready(host_rx_ready),
    .host_tx_data (host_tx_data),
    .host_tx_valid(host_tx_valid),
    .host_tx_ready(host_tx_ready),
    .rx_level     (rx_level),
    .tx_level     (tx_level),
    .err_underrun (err_underrun),
    .err_overrun  (err_overrun),
    .clr_err      (clr_err)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after the active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    ft_rd_n = 1'b1; ft_wr_n = 1'b1; ft_oe_n = 1'b1;
    ft_data_in = 8'h00; host_rx_data = 8'h00; host_rx_valid = 1'b0;
    host_tx_ready = 1'b0; clr_err = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    tests_run++;
    if ({ft_rxf_n, ft_txe_n, host_rx_ready, host_tx_valid} !== 4'b1010) begin
      tests_failed++;
      $display("FAIL reset_status: got rxf_n/txe_n/rx_ready/tx_valid=%b expected 1010",
               {ft_rxf_n, ft_txe_n, host_rx_ready, host_tx_valid});
    end
    tests_run++;
    if ({rx_level, tx_level} !== 10'd0) begin
      tests_failed++;
      $display("FAIL reset_levels: got rx=%0d tx=%0d expected 0/0", rx_level, tx_level);
    end
    tests_run++;
    if ({err_underrun, err_overrun, ft_data_out, host_tx_data} !== 18'd0) begin
      tests_failed++;
      $display("FAIL reset_data_err: got uf=%b of=%b dout=%h htx=%h expected all 0",
               err_underrun, err_overrun, ft_data_out, host_tx_data);
    end
  endtask

  task automatic test_rx_basic();
    host_rx_valid = 1'b1; host_rx_data = 8'hA5; tick();
    host_rx_data = 8'h3C; tick();
    host_rx_valid = 1'b0;
    ft_oe_n = 1'b0;
    #1;
    tests_run++;
    if (ft_data_oe !== 1'b1 || rx_level !== 5'd2 || ft_rxf_n !== 1'b0) begin
      tests_failed++;
      $display("FAIL rx_two_queued: got oe=%b lvl=%0d rxf_n=%b expected 1 2 0",
               ft_data_oe, rx_level, ft_rxf_n);
    end
    tests_run++;
    if (ft_data_out !== 8'hA5) begin
      tests_failed++;
      $display("FAIL rx_head_first: got %h expected a5", ft_data_out);
    end
    ft_rd_n = 1'b0; tick(); ft_rd_n = 1'b1;
    tests_run++;
    if (ft_data_out !== 8'h3C || rx_level !== 5'd1) begin
      tests_failed++;
      $display("FAIL rx_pop1: got dout=%h lvl=%0d expected 3c 1", ft_data_out, rx_level);
    end
    ft_rd_n = 1'b0; tick(); ft_rd_n = 1'b1;
    tests_run++;
    if (ft_rxf_n !== 1'b1 || rx_level !== 5'd0 || ft_data_out !== 8'h00) begin
      tests_failed++;
      $display("FAIL rx_pop2: got rxf_n=%b lvl=%0d dout=%h expected 1 0 00",
               ft_rxf_n, rx_level, ft_data_out);
    end
    ft_oe_n = 1'b1;
    #1;
    tests_run++;
    if (ft_data_oe !== 1'b0) begin
      tests_failed++;
      $display("FAIL oe_release: got %b expected 0", ft_data_oe);
    end
  endtask

  task automatic test_tx_fill();
    logic [7:0] exp;
    for (int i = 0; i < 16; i++) begin
      ft_wr_n = 1'b0; ft_data_in = 8'h11 + 8'(i); tick();
    end
    ft_wr_n = 1'b1;
    tests_run++;
    if (ft_txe_n !== 1'b1 || tx_level !== 5'd16 || err_overrun !== 1'b0) begin
      tests_failed++;
      $display("FAIL tx_full: got txe_n=%b lvl=%0d of=%b expected 1 16 0",
               ft_txe_n, tx_level, err_overrun);
    end
    ft_wr_n = 1'b0; ft_data_in = 8'h99; tick(); ft_wr_n = 1'b1;
    tests_run++;
    if (err_overrun !== 1'b1 || tx_level !== 5'd16) begin
      tests_failed++;
      $display("FAIL tx_overrun: got of=%b lvl=%0d expected 1 16", err_overrun, tx_level);
    end
    host_tx_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      exp = 8'h11 + 8'(i);
      tests_run++;
      if (host_tx_data !== exp || host_tx_valid !== 1'b1) begin
        tests_failed++;
        $display("FAIL tx_drain[%0d]: got %h valid=%b expected %h valid=1",
                 i, host_tx_data, host_tx_valid, exp);
      end
      tick();
    end
    host_tx_ready = 1'b0;
    tests_run++;
    if (host_tx_valid !== 1'b0 || tx_level !== 5'd0 || ft_txe_n !== 1'b0) begin
      tests_failed++;
      $display("FAIL tx_empty: got valid=%b lvl=%0d txe_n=%b expected 0 0 0",
               host_tx_valid, tx_level, ft_txe_n);
    end
    clr_err = 1'b1; tick(); clr_err = 1'b0;
    tests_run++;
    if (err_overrun !== 1'b0) begin
      tests_failed++;
      $display("FAIL overrun_clear: got %b expected 0", err_overrun);
    end
  endtask

  task automatic test_underrun();
    ft_rd_n = 1'b0; tick(); ft_rd_n = 1'b1;
    tests_run++;
    if (err_underrun !== 1'b1 || rx_level !== 5'd0) begin
      tests_failed++;
      $display("FAIL underrun_set: got uf=%b lvl=%0d expected 1 0", err_underrun, rx_level);
    end
    clr_err = 1'b1; tick(); clr_err = 1'b0;
    tests_run++;
    if (err_underrun !== 1'b0) begin
      tests_failed++;
      $display("FAIL underrun_clear: got %b expected 0", err_underrun);
    end
    // New error and clear on the same edge: the error wins.
    ft_rd_n = 1'b0; clr_err = 1'b1; tick(); ft_rd_n = 1'b1; clr_err = 1'b0;
    tests_run++;
    if (err_underrun !== 1'b1) begin
      tests_failed++;
      $display("FAIL underrun_vs_clear: got %b expected 1", err_underrun);
    end
    clr_err = 1'b1; tick(); clr_err = 1'b0;
  endtask

  task automatic test_rx_full_collision();
    logic [7:0] exp;
    host_rx_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      host_rx_data = 8'h40 + 8'(i); tick();
    end
    host_rx_valid = 1'b0;
    tests_run++;
    if (rx_level !== 5'd16 || host_rx_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL rx_full: got lvl=%0d ready=%b expected 16 0", rx_level, host_rx_ready);
    end
    host_rx_valid = 1'b1; host_rx_data = 8'h77; ft_rd_n = 1'b0;
    tick();
    ft_rd_n = 1'b1;
    tests_run++;
    if (rx_level !== 5'd15 || host_rx_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL rx_full_collide: got lvl=%0d ready=%b expected 15 1",
               rx_level, host_rx_ready);
    end
    tick();
    host_rx_valid = 1'b0;
    tests_run++;
    if (rx_level !== 5'd16) begin
      tests_failed++;
      $display("FAIL rx_retry_push: got lvl=%0d expected 16", rx_level);
    end
    // Held-low drain: one byte per cycle, then underrun on the first empty cycle.
    ft_rd_n = 1'b0;
    for (int i = 0; i < 16; i++) begin
      exp = (i < 15) ? 8'h41 + 8'(i) : 8'h77;
      tests_run++;
      if (ft_data_out !== exp) begin
        tests_failed++;
        $display("FAIL rx_stream[%0d]: got %h expected %h", i, ft_data_out, exp);
      end
      tick();
    end
    tests_run++;
    if (err_underrun !== 1'b0 || rx_level !== 5'd0) begin
      tests_failed++;
      $display("FAIL rx_stream_end: got uf=%b lvl=%0d expected 0 0", err_underrun, rx_level);
    end
    tick();
    ft_rd_n = 1'b1;
    tests_run++;
    if (err_underrun !== 1'b1 || rx_level !== 5'd0) begin
      tests_failed++;
      $display("FAIL rx_stream_underrun: got uf=%b lvl=%0d expected 1 0",
               err_underrun, rx_level);
    end
    clr_err = 1'b1; tick(); clr_err = 1'b0;
  endtask

  task automatic test_both_strobes();
    host_rx_valid = 1'b1; host_rx_data = 8'hC3; tick(); host_rx_valid = 1'b0;
    ft_rd_n = 1'b0; ft_wr_n = 1'b0; ft_data_in = 8'h5A;
    tick();
    ft_rd_n = 1'b1; ft_wr_n = 1'b1;
    tests_run++;
    if (rx_level !== 5'd0 || tx_level !== 5'd1 || host_tx_data !== 8'h5A ||
        err_underrun !== 1'b0) begin
      tests_failed++;
      $display("FAIL both_strobes: got rx=%0d tx=%0d htx=%h uf=%b expected 0 1 5a 0",
               rx_level, tx_level, host_tx_data, err_underrun);
    end
    host_tx_ready = 1'b1; tick(); host_tx_ready = 1'b0;
  endtask

  task automatic test_wraparound();
    logic [7:0] r1, r2;
    int bad;
    rx_q.delete(); tx_q.delete();
    for (int i = 0; i < 3; i++) begin
      r1 = 8'($urandom_range(0, 255)); r2 = 8'($urandom_range(0, 255));
      host_rx_valid = 1'b1; host_rx_data = r1; ft_wr_n = 1'b0; ft_data_in = r2;
      rx_q.push_back(r1); tx_q.push_back(r2);
      tick();
    end
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      r1 = 8'($urandom_range(0, 255)); r2 = 8'($urandom_range(0, 255));
      host_rx_data = r1; ft_data_in = r2;
      ft_rd_n = 1'b0; host_tx_ready = 1'b1;
      #1;
      tests_run++;
      if (ft_data_out !== rx_q[0] || host_tx_data !== tx_q[0]) begin
        tests_failed++;
        $display("FAIL wrap_data[%0d]: got rx=%h tx=%h expected rx=%h tx=%h",
                 i, ft_data_out, host_tx_data, rx_q[0], tx_q[0]);
      end
      tick();
      void'(rx_q.pop_front()); void'(tx_q.pop_front());
      rx_q.push_back(r1); tx_q.push_back(r2);
      if (rx_level !== 5'(rx_q.size()) || tx_level !== 5'(tx_q.size()) ||
          rx_level > 5'd16 || tx_level > 5'd16) bad++;
    end
    host_rx_valid = 1'b0; ft_wr_n = 1'b1;
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("FAIL wrap_levels: got %0d bad cycles (rx=%0d tx=%0d) expected 0 (3/3)",
               bad, rx_level, tx_level);
    end
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if (ft_data_out !== rx_q[i] || host_tx_data !== tx_q[i]) begin
        tests_failed++;
        $display("FAIL wrap_drain[%0d]: got rx=%h tx=%h expected rx=%h tx=%h",
                 i, ft_data_out, host_tx_data, rx_q[i], tx_q[i]);
      end
      tick();
    end
    ft_rd_n = 1'b1; host_tx_ready = 1'b0;
    tests_run++;
    if (rx_level !== 5'd0 || tx_level !== 5'd0) begin
      tests_failed++;
      $display("FAIL wrap_empty: got rx=%0d tx=%0d expected 0 0", rx_level, tx_level);
    end
  endtask

  task automatic test_async_reset();
    host_rx_valid = 1'b1; ft_wr_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      host_rx_data = 8'hE0 + 8'(i); ft_data_in = 8'hD0 + 8'(i); tick();
    end
    host_rx_valid = 1'b0; ft_wr_n = 1'b1;
    tests_run++;
    if (rx_level !== 5'd5 || tx_level !== 5'd5) begin
      tests_failed++;
      $display("FAIL pre_reset_levels: got rx=%0d tx=%0d expected 5 5", rx_level, tx_level);
    end
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if (ft_rxf_n !== 1'b1 || rx_level !== 5'd0 || tx_level !== 5'd0 ||
        host_tx_valid !== 1'b0 || ft_txe_n !== 1'b0) begin
      tests_failed++;
      $display("FAIL async_reset: got rxf_n=%b rx=%0d tx=%0d txv=%b txe_n=%b expected 1 0 0 0 0",
               ft_rxf_n, rx_level, tx_level, host_tx_valid, ft_txe_n);
    end
    #2 rst_n = 1'b1;
    tick();
    tests_run++;
    if (rx_level !== 5'd0 || tx_level !== 5'd0 || ft_data_out !== 8'h00) begin
      tests_failed++;
      $display("FAIL post_reset: got rx=%0d tx=%0d dout=%h expected 0 0 00",
               rx_level, tx_level, ft_data_out);
    end
  endtask

  initial begin
    test_reset();
    test_rx_basic();
    test_tx_fill();
    test_underrun();
    test_rx_full_collision();
    test_both_strobes();
    test_wraparound();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/ftdi_fifo_responder.md
Name: ftdi_fifo_responder

Overview:
- Synthesizable model of the FT245-style synchronous FIFO device that the SNES-Hook CPLD drives through USB_RDn/USB_WRn/USB_OEn and samples through USB_RXFn/USB_TXEn.
- Intended use: the host-side FPGA in place of the FTDI part, and the device model in the SNES-Hook system bench.
- Contains two byte FIFOs:
  - RX: host to SNES; host pushes, SNES side pops via rd_n.
  - TX: SNES to host; SNES side pushes via wr_n, host pops.
- Presents FT245 status and data pins on one side and valid/ready byte streams on the other.

Parameters:
- DEPTH_LOG2, default 4: log2 of the entry count of each FIFO (16 entries).

Ports:
- clk  in  1  FIFO clock; the USB_CLK seen by the hook.
- rst_n  in  1  asynchronous active-low reset.
- ft_rd_n  in  1  pop strobe for the RX FIFO; sampled on the clk rising edge.
- ft_wr_n  in  1  push strobe for the TX FIFO; sampled on the clk rising edge.
- ft_oe_n  in  1  output enable for ft_data_out.
- ft_rxf_n  out  1  low when the RX FIFO holds at least one byte.
- ft_txe_n  out  1  low when the TX FIFO can accept a byte.
- ft_data_in  in  8  byte written by the SNES side.
- ft_data_out  out  8  head of the RX FIFO.
- ft_data_oe  out  1  drive enable for the shared data pins.
- host_rx_data  in  8  byte to queue toward the SNES.
- host_rx_valid  in  1  push request into the RX FIFO.
- host_rx_ready  out  1  RX FIFO not full.
- host_tx_data  out  8  head of the TX FIFO.
- host_tx_valid  out  1  TX FIFO not empty.
- host_tx_ready  in  1  host accepts host_tx_data.
- rx_level  out  DEPTH_LOG2+1  RX FIFO occupancy.
- tx_level  out  DEPTH_LOG2+1  TX FIFO occupancy.
- err_underrun  out  1  sticky: rd_n asserted while the RX FIFO was empty.
- err_overrun  out  1  sticky: wr_n asserted while the TX FIFO was full.
- clr_err  in  1  synchronous clear of both sticky error flags.

Behaviour:
- Reset values (asynchronous, on rst_n low):
  - All pointers and levels = 0.
  - ft_rxf_n=1, ft_txe_n=0, host_rx_ready=1, host_tx_valid=0.
  - ft_data_out=0, host_tx_data=0, err flags=0.
- Reset mid-operation discards all queued bytes; no partial transfer completes.
- Both FIFOs are first-word-fall-through circular buffers:
  - Pointers are DEPTH_LOG2+1 bits and wrap modulo 2^(DEPTH_LOG2+1).
  - full = (level == 2^DEPTH_LOG2); empty = (level == 0).
- RX push: on the edge where host_rx_valid & host_rx_ready, host_rx_data is written and rx_level increments.
- RX pop: on the edge where ~ft_rd_n & ~empty, the head advances and rx_level decrements.
- RX simultaneous push and pop:
  - Both occur; level is unchanged.
  - When full, host_rx_ready=0 blocks the push regardless of the concurrent pop (readiness is decided on pre-edge state).
  - When empty, the pop is an underrun and the push still occurs.
- ~ft_rd_n while empty: no pointer change; err_underrun set on that edge.
- ft_rd_n is level-sampled: N consecutive low cycles pop N bytes, or stop at empty, with the underrun flag set on the first empty cycle.
- TX push: on the edge where ~ft_wr_n & ~full, ft_data_in is written and tx_level increments.
- ~ft_wr_n while full: byte dropped; err_overrun set.
- TX pop: on the edge where host_tx_valid & host_tx_ready, the head advances.
- TX simultaneous push and pop: both occur; when full, the push is refused per the pre-edge full state.
- ft_rd_n and ft_wr_n low in the same cycle: both honoured independently.
- ft_rxf_n = empty_rx and ft_txe_n = full_tx.
  - Both are combinational from levels, so they reflect the post-edge state with zero added latency.
  - A byte pushed by the host is visible on ft_rxf_n in the cycle after the push edge.
- ft_data_out = RX head (combinational from the read pointer), or 0 when empty.
- ft_data_oe = ~ft_oe_n; asynchronous; no clock dependency.
- host_tx_data = TX head, or 0 when empty.
- clr_err: the flags clear on the edge where clr_err=1.
  - A new error on the same edge wins: the flag is set.
- Storage: two 2^DEPTH_LOG2 x 8 register arrays.
  - No read latency.
  - Storage is not reset; only pointers are reset.

Test Plan:
- Reset then idle: after rst_n release, ft_rxf_n=1, ft_txe_n=0, host_rx_ready=1, rx_level=0, tx_level=0, no error flags.
- Host pushes 0xA5, 0x3C; then ft_oe_n=0 and one-cycle ft_rd_n pulses:
  - ft_data_oe=1; ft_data_out=0xA5, then 0x3C after the first pulse.
  - ft_rxf_n=1 after the second pulse; rx_level 2→1→0.
- SNES side pulses ft_wr_n with 0x11..0x20 (16 bytes):
  - ft_txe_n=1 after the 16th.
  - A 17th pulse with 0x99 is dropped, err_overrun=1, tx_level=16.
  - Host drains in order 0x11..0x20.
- ft_rd_n low while RX empty: err_underrun=1, rx_level stays 0; clr_err pulse clears it the next edge.
- RX at level 16 with host_rx_valid=1 and ft_rd_n=0 in the same cycle:
  - Pop occurs, push is refused (ready=0), level becomes 15.
  - The next cycle the push is accepted, level 16.
- Wrap-around: 40 interleaved push/pop pairs on both FIFOs with random data; the scoreboard matches byte order exactly and levels never exceed 16.
- Assert rst_n low with 5 bytes queued: ft_rxf_n=1 and levels 0 immediately, asynchronously to clk.
